// File: rtl/ex_muldiv_if.sv
// Issue/writeback bundle between the execute stage and the multi-cycle M-extension unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            hold_flag_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o;

  modport master (
    output start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  busy_o, hold_flag_o, valid_o, result_o, rd_addr_o, reg_wen_o
  );

  modport slave (
    input  start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
    output busy_o, hold_flag_o, valid_o, result_o, rd_addr_o, reg_wen_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M unit: counted-latency multiplier plus restoring radix-2 divider,
// stalling the pipeline until the result is written back.
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_EARLY  = 1
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW           = $clog2(XLEN);
  localparam int MUL_CNT_INIT = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [1:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            q_neg;
  logic            r_neg;
  logic            special;
  logic            fix;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic idle;
  logic valid;

  assign idle            = (state == S_IDLE);
  assign valid           = (state == S_DONE) & ~bus.flush_i;
  assign bus.busy_o      = ~idle;
  assign bus.hold_flag_o = ~idle | (bus.start_i & idle);
  assign bus.valid_o     = valid;
  assign bus.reg_wen_o   = valid;
  assign bus.result_o    = result_q;
  assign bus.rd_addr_o   = rd_out_q;

  // With a single-cycle multiply the product must come straight from the issue operands.
  logic                use_in;
  logic [XLEN-1:0]     mul_a;
  logic [XLEN-1:0]     mul_b;
  logic [1:0]          mul_f;
  logic                a_sgn;
  logic                b_sgn;
  logic [2*XLEN-1:0]   a_ext;
  logic [2*XLEN-1:0]   b_ext;
  logic [2*XLEN-1:0]   product;
  logic [XLEN-1:0]     mul_res;

  always_comb begin
    use_in  = (MUL_STAGES == 1) && idle;
    mul_a   = use_in ? bus.op1_i : op1_q;
    mul_b   = use_in ? bus.op2_i : op2_q;
    mul_f   = use_in ? bus.func3_i[1:0] : f3_q;
    a_sgn   = (mul_f == 2'b01) || (mul_f == 2'b10);
    b_sgn   = (mul_f == 2'b01);
    a_ext   = {{XLEN{a_sgn & mul_a[XLEN-1]}}, mul_a};
    b_ext   = {{XLEN{b_sgn & mul_b[XLEN-1]}}, mul_b};
    product = a_ext * b_ext;
    mul_res = (mul_f == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  logic            in_signed;
  logic            in_a_neg;
  logic            in_b_neg;
  logic            in_div0;
  logic            in_ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  always_comb begin
    in_signed = ~bus.func3_i[0];
    in_a_neg  = in_signed & bus.op1_i[XLEN-1];
    in_b_neg  = in_signed & bus.op2_i[XLEN-1];
    abs_a     = in_a_neg ? -bus.op1_i : bus.op1_i;
    abs_b     = in_b_neg ? -bus.op2_i : bus.op2_i;
    in_div0   = (bus.op2_i == '0);
    in_ovf    = in_signed && (bus.op1_i == MIN_NEG) && (bus.op2_i == '1);
  end

  // The dividend shifts out of quo_q into rem_q while quotient bits shift in behind it.
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    diff    = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    ge      = ~diff[XLEN];
    quo_fix = q_neg ? -quo_q : quo_q;
    rem_fix = r_neg ? -rem_q : rem_q;
    div_res = f3_q[1] ? rem_fix : quo_fix;
    if (op2_q == '0) spec_res = f3_q[1] ? op1_q : '1;
    else             spec_res = f3_q[1] ? '0 : op1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      special  <= 1'b0;
      fix      <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (bus.flush_i) begin
      state <= S_IDLE;
      fix   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            op1_q <= bus.op1_i;
            op2_q <= bus.op2_i;
            f3_q  <= bus.func3_i[1:0];
            rd_q  <= bus.rd_addr_i;
            if (bus.func3_i[2]) begin
              state   <= S_DIV;
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              q_neg   <= in_a_neg ^ in_b_neg;
              r_neg   <= in_a_neg;
              special <= in_div0 | in_ovf;
              fix     <= 1'b0;
              cnt     <= CW'(XLEN - 1);
            end else if (MUL_STAGES == 1) begin
              state    <= S_DONE;
              result_q <= mul_res;
              rd_out_q <= bus.rd_addr_i;
            end else begin
              state <= S_MUL;
              cnt   <= CW'(MUL_CNT_INIT);
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            state    <= S_DONE;
            result_q <= mul_res;
            rd_out_q <= rd_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (special && (DIV_EARLY != 0)) begin
            state    <= S_DONE;
            result_q <= spec_res;
            rd_out_q <= rd_q;
          end else if (fix) begin
            state    <= S_DONE;
            fix      <= 1'b0;
            result_q <= special ? spec_res : div_res;
            rd_out_q <= rd_q;
          end else begin
            rem_q <= ge ? diff[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_q <= {quo_q[XLEN-2:0], ge};
            if (cnt == '0) fix <= 1'b1;
            else           cnt <= cnt - CW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
